pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage pipelined CPU. It detects load-use hazards, taken-branch control hazards and multi-cycle data-memory waits. It drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers. It also keeps saturating performance counters and a sticky memory-timeout error.

## Interface
Parameters:
- LU_BUBBLES, 1: bubbles inserted per load-use hazard. Legal values are 1 and 2.
- MEM_TIMEOUT, 255: maximum consecutive memory-wait cycles before error.
- CNT_W, 16: performance counter width.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- ifid_rs_i  in  5  rs field of the instruction in ID
- ifid_rt_i  in  5  rt field of the instruction in ID
- ifid_uses_rt_i  in  1  instruction in ID reads rt as a source
- idex_memread_i  in  1  instruction in EX is a load
- idex_rt_i  in  5  destination register of the load in EX
- branch_taken_i  in  1  taken branch resolved in MEM (PCSrc)
- dmem_req_i  in  1  MEM stage accesses data memory (MemRead|MemWrite)
- dmem_ready_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID loads NOP
- idex_bubble_o  out  1  ID/EX loads zero control
- exmem_hold_o  out  1  EX/MEM holds its contents
- exmem_bubble_o  out  1  EX/MEM loads zero control
- memwb_bubble_o  out  1  MEM/WB loads zero control
- err_o  out  1  sticky memory-timeout error
- lu_cnt_o  out  CNT_W  load-use bubbles inserted
- flush_cnt_o  out  CNT_W  branch flushes
- wait_cnt_o  out  CNT_W  memory freeze cycles

## Operation
States: RUN, LU_STALL, MEM_WAIT, ERROR.

Hazard terms:
- hz_mem = dmem_req_i & ~dmem_ready_i
- hz_lu = idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)))

Actions, in priority order (highest first), evaluated in RUN:
1. **Freeze**, when hz_mem.
   - pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, exmem_hold_o=1, memwb_bubble_o=1.
   - Next state MEM_WAIT; wait counter loads 1.
2. **Flush**, when branch_taken_i.
   - pc_write_o=1, ifid_flush_o=1, idex_bubble_o=1, exmem_bubble_o=1.
   - flush_cnt_o increments.
3. **Load-use**, when hz_lu.
   - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
   - lu_cnt_o increments.
   - If LU_BUBBLES=2, next state is LU_STALL.
4. **Default**: pc_write_o=1, ifid_write_o=1, every flush, bubble and hold output 0.

LU_STALL:
- Outputs are the load-use pattern; lu_cnt_o increments; next state RUN.
- hz_mem takes precedence: apply Freeze and go to MEM_WAIT.
- branch_taken_i takes precedence: apply Flush and go to RUN.

MEM_WAIT:
- Outputs are the Freeze pattern while ~dmem_ready_i.
- The wait counter increments each cycle. When it reaches MEM_TIMEOUT with the memory still not ready, next state is ERROR.
- The cycle dmem_ready_i=1 is evaluated exactly as RUN (flush, load-use or default) and the next state follows the RUN rules.

ERROR:
- err_o=1, Freeze pattern permanently.
- Exits only through rst_i.

Counters:
- All three saturate at 2^CNT_W-1; they do not wrap.
- wait_cnt_o increments on every Freeze cycle, including in ERROR.

Simultaneous events:
- hz_mem with branch_taken_i: Freeze wins. The flush is applied on the ready cycle, because branch_taken_i is held while EX/MEM is frozen.
- branch_taken_i with hz_lu: Flush wins. The stalled instruction is squashed and no load-use count is recorded.

## Timing
- All *_write_o, *_flush_o, *_bubble_o and *_hold_o outputs are combinational from state and same-cycle inputs (Mealy). The pipe registers consume them at the next rising edge.
- State, counters and err_o are registered.
- Reset: any cycle with rst_i=1 forces, at that edge:
  - state to RUN, all counters to 0, err_o to 0, wait counter to 0.
  - While rst_i=1, outputs take the Default pattern regardless of inputs.
- Load-use penalty is exactly LU_BUBBLES cycles.
- Branch penalty is 3 squashed instructions, flushed in one cycle.
- Freeze duration equals the number of cycles with dmem_ready_i low.
- ERROR is entered on the edge after wait count == MEM_TIMEOUT with ready still low.

## Test plan
- lw $2 in EX, add $3,$2,$4 in ID (rs=2), LU_BUBBLES=1:
  - exactly one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, then Default; lu_cnt_o=1.
  - Repeat with idex_rt_i=0: no stall.
- Same hazard with LU_BUBBLES=2: two consecutive stall cycles; lu_cnt_o=2.
- branch_taken_i=1 for one cycle:
  - ifid_flush_o, idex_bubble_o and exmem_bubble_o all 1 in that cycle; flush_cnt_o=1.
  - With hz_lu also true: flush pattern only, lu_cnt_o unchanged.
- dmem_req_i=1, dmem_ready_i low for 3 cycles then high:
  - Freeze for 3 cycles; wait_cnt_o=3.
  - With branch_taken_i held during the wait, the flush appears on the ready cycle.
- MEM_TIMEOUT=4, ready never asserted:
  - err_o rises after the 4th wait cycle and stays high with outputs frozen.
  - rst_i pulse clears err_o and all counters; Default outputs resume.
- CNT_W=2, five load-use hazards: lu_cnt_o saturates at 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs, pipe-register controls and status of the hazard controller.
// master: pipeline datapath side; slave: pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             ifid_uses_rt_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ready_i;

  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             exmem_hold_o;
  logic             exmem_bubble_o;
  logic             memwb_bubble_o;
  logic             err_o;
  logic [CNT_W-1:0] lu_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] wait_cnt_o;

  modport master (
    output ifid_rs_i,
    output ifid_rt_i,
    output ifid_uses_rt_i,
    output idex_memread_i,
    output idex_rt_i,
    output branch_taken_i,
    output dmem_req_i,
    output dmem_ready_i,
    input  pc_write_o,
    input  ifid_write_o,
    input  ifid_flush_o,
    input  idex_bubble_o,
    input  exmem_hold_o,
    input  exmem_bubble_o,
    input  memwb_bubble_o,
    input  err_o,
    input  lu_cnt_o,
    input  flush_cnt_o,
    input  wait_cnt_o
  );

  modport slave (
    input  ifid_rs_i,
    input  ifid_rt_i,
    input  ifid_uses_rt_i,
    input  idex_memread_i,
    input  idex_rt_i,
    input  branch_taken_i,
    input  dmem_req_i,
    input  dmem_ready_i,
    output pc_write_o,
    output ifid_write_o,
    output ifid_flush_o,
    output idex_bubble_o,
    output exmem_hold_o,
    output exmem_bubble_o,
    output memwb_bubble_o,
    output err_o,
    output lu_cnt_o,
    output flush_cnt_o,
    output wait_cnt_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, dmem freeze.
// Ports: clk_i, rst_i (sync, active-high), hz (slave side of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int WW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TO_LAST =
    WW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT,
    ERROR
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_n;

  logic hz_mem;
  logic hz_lu;
  logic run_eval;
  logic frz;
  logic fls;
  logic lus;

  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] fl_cnt;
  logic [CNT_W-1:0] wt_cnt;

  assign hz_mem = hz.dmem_req_i & ~hz.dmem_ready_i;

  assign hz_lu = hz.idex_memread_i
               & (hz.idex_rt_i != 5'd0)
               & ((hz.idex_rt_i == hz.ifid_rs_i)
               | (hz.ifid_uses_rt_i
               & (hz.idex_rt_i == hz.ifid_rt_i)));

  // The ready cycle of a memory wait is judged
  // exactly like a RUN cycle.
  assign run_eval = (state == RUN)
                  | ((state == MEM_WAIT)
                  & hz.dmem_ready_i);

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    frz     = 1'b0;
    fls     = 1'b0;
    lus     = 1'b0;

    unique case (state)
      RUN: begin
      end
      LU_STALL: begin
        if (hz_mem) begin
          frz     = 1'b1;
          wcnt_n  = WW'(1);
          state_n = MEM_WAIT;
        end else if (hz.branch_taken_i) begin
          fls     = 1'b1;
          state_n = RUN;
        end else begin
          lus     = 1'b1;
          state_n = RUN;
        end
      end
      MEM_WAIT: begin
        if (!hz.dmem_ready_i) begin
          frz    = 1'b1;
          wcnt_n = wcnt + 1'b1;
          if (wcnt >= TO_LAST) begin
            state_n = ERROR;
          end
        end
      end
      ERROR: begin
        frz = 1'b1;
      end
    endcase

    if (run_eval) begin
      if (hz_mem) begin
        frz     = 1'b1;
        wcnt_n  = WW'(1);
        state_n = MEM_WAIT;
      end else if (hz.branch_taken_i) begin
        fls     = 1'b1;
        state_n = RUN;
      end else if (hz_lu) begin
        lus     = 1'b1;
        state_n = (LU_BUBBLES == 2) ? LU_STALL : RUN;
      end else begin
        state_n = RUN;
      end
    end

    // Outputs fall back to the default pattern in reset.
    if (rst_i) begin
      frz = 1'b0;
      fls = 1'b0;
      lus = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= RUN;
      wcnt   <= '0;
      lu_cnt <= '0;
      fl_cnt <= '0;
      wt_cnt <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (lus && lu_cnt != CMAX) begin
        lu_cnt <= lu_cnt + 1'b1;
      end
      if (fls && fl_cnt != CMAX) begin
        fl_cnt <= fl_cnt + 1'b1;
      end
      if (frz && wt_cnt != CMAX) begin
        wt_cnt <= wt_cnt + 1'b1;
      end
    end
  end

  assign hz.pc_write_o     = ~frz & ~lus;
  assign hz.ifid_write_o   = ~frz & ~lus & ~fls;
  assign hz.ifid_flush_o   = fls;
  assign hz.idex_bubble_o  = fls | lus;
  assign hz.exmem_hold_o   = frz;
  assign hz.exmem_bubble_o = fls;
  assign hz.memwb_bubble_o = frz;

  assign hz.err_o       = (state == ERROR);
  assign hz.lu_cnt_o    = lu_cnt;
  assign hz.flush_cnt_o = fl_cnt;
  assign hz.wait_cnt_o  = wt_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations on shared stimulus,
// directed literal checks plus a per-cycle behavioural model compare.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] DEF = 7'b1100000;
  localparam logic [6:0] FRZ = 7'b0000101;
  localparam logic [6:0] FLS = 7'b1011010;
  localparam logic [6:0] LUP = 7'b0001000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] xrt;
  logic       ut;
  logic       mr;
  logic       br;
  logic       req;
  logic       rdy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(2)) hz_a ();
  pipe_hazard_ctrl_if #(.CNT_W(8)) hz_b ();

  assign hz_a.ifid_rs_i      = rs;
  assign hz_a.ifid_rt_i      = rt;
  assign hz_a.ifid_uses_rt_i = ut;
  assign hz_a.idex_memread_i = mr;
  assign hz_a.idex_rt_i      = xrt;
  assign hz_a.branch_taken_i = br;
  assign hz_a.dmem_req_i     = req;
  assign hz_a.dmem_ready_i   = rdy;

  assign hz_b.ifid_rs_i      = rs;
  assign hz_b.ifid_rt_i      = rt;
  assign hz_b.ifid_uses_rt_i = ut;
  assign hz_b.idex_memread_i = mr;
  assign hz_b.idex_rt_i      = xrt;
  assign hz_b.branch_taken_i = br;
  assign hz_b.dmem_req_i     = req;
  assign hz_b.dmem_ready_i   = rdy;

  pipe_hazard_ctrl #(
    .LU_BUBBLES(1), .MEM_TIMEOUT(4), .CNT_W(2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .hz(hz_a)
  );

  pipe_hazard_ctrl #(
    .LU_BUBBLES(2), .MEM_TIMEOUT(6), .CNT_W(8)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .hz(hz_b)
  );

  wire logic [6:0] oa = {hz_a.pc_write_o, hz_a.ifid_write_o,
    hz_a.ifid_flush_o, hz_a.idex_bubble_o, hz_a.exmem_hold_o,
    hz_a.exmem_bubble_o, hz_a.memwb_bubble_o};
  wire logic [6:0] ob = {hz_b.pc_write_o, hz_b.ifid_write_o,
    hz_b.ifid_flush_o, hz_b.idex_bubble_o, hz_b.exmem_hold_o,
    hz_b.exmem_bubble_o, hz_b.memwb_bubble_o};

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Behavioural model: remaining forced bubbles, length of the
  // current memory wait, a dead flag and saturating event counts.
  int mlb [2] = '{1, 2};
  int mto [2] = '{4, 6};
  int mcx [2] = '{3, 255};
  int pend[2] = '{0, 0};
  int wlen[2] = '{0, 0};
  bit inw [2] = '{0, 0};
  bit dead[2] = '{0, 0};
  int lu  [2] = '{0, 0};
  int fl  [2] = '{0, 0};
  int wt  [2] = '{0, 0};

  function automatic bit m_hz_lu();
    return mr && xrt != 0 &&
           (xrt == rs || (ut && xrt == rt));
  endfunction

  function automatic logic [6:0] m_out(int k);
    if (rst) return DEF;
    if (dead[k]) return FRZ;
    if (inw[k] ? !rdy : (req && !rdy)) return FRZ;
    if (br) return FLS;
    if (pend[k] > 0 || m_hz_lu()) return LUP;
    return DEF;
  endfunction

  function automatic int sat(int v, int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic m_step(int k);
    logic [6:0] o;
    o = m_out(k);
    if (rst) begin
      pend[k] = 0; wlen[k] = 0; inw[k] = 0;
      dead[k] = 0; lu[k] = 0; fl[k] = 0; wt[k] = 0;
    end else if (o == FRZ) begin
      wt[k] = sat(wt[k], mcx[k]);
      pend[k] = 0;
      if (!dead[k]) begin
        if (inw[k]) begin
          wlen[k]++;
          if (wlen[k] >= mto[k]) dead[k] = 1;
        end else begin
          inw[k] = 1;
          wlen[k] = 1;
        end
      end
    end else if (o == FLS) begin
      fl[k] = sat(fl[k], mcx[k]);
      inw[k] = 0; pend[k] = 0;
    end else if (o == LUP) begin
      lu[k] = sat(lu[k], mcx[k]);
      inw[k] = 0;
      if (pend[k] > 0) pend[k]--;
      else pend[k] = mlb[k] - 1;
    end else begin
      inw[k] = 0; pend[k] = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model_a_outs", 32'(oa), 32'(m_out(0)));
      chk("model_a_lu", 32'(hz_a.lu_cnt_o), lu[0]);
      chk("model_a_flush", 32'(hz_a.flush_cnt_o), fl[0]);
      chk("model_a_wait", 32'(hz_a.wait_cnt_o), wt[0]);
      chk("model_a_err", 32'(hz_a.err_o), 32'(dead[0]));
      chk("model_b_outs", 32'(ob), 32'(m_out(1)));
      chk("model_b_lu", 32'(hz_b.lu_cnt_o), lu[1]);
      chk("model_b_flush", 32'(hz_b.flush_cnt_o), fl[1]);
      chk("model_b_wait", 32'(hz_b.wait_cnt_o), wt[1]);
      chk("model_b_err", 32'(hz_b.err_o), 32'(dead[1]));
      @(posedge clk);
      m_step(0);
      m_step(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs = 0; rt = 0; ut = 0; mr = 0;
    xrt = 0; br = 0; req = 0; rdy = 1;
  endtask

  task automatic lu_hz();
    mr = 1; xrt = 5'd2; rs = 5'd2; rt = 5'd4; ut = 1;
  endtask

  initial begin
    rst = 1;
    idle();
    lu_hz();
    req = 1; rdy = 0;
    @(negedge clk);
    chk("rst_outs_a", 32'(oa), 32'(DEF));
    chk("rst_outs_b", 32'(ob), 32'(DEF));
    tick();
    idle();
    @(negedge clk);
    chk("rst_lu_a", 32'(hz_a.lu_cnt_o), 0);
    chk("rst_err_a", 32'(hz_a.err_o), 0);
    tick();
    rst = 0;
    lu_hz();
    @(negedge clk);
    chk("lu_stall_a", 32'(oa), 32'(LUP));
    chk("lu_stall_b", 32'(ob), 32'(LUP));
    tick();
    idle();
    @(negedge clk);
    chk("lu_done_a", 32'(oa), 32'(DEF));
    chk("lu_second_b", 32'(ob), 32'(LUP));
    chk("lu_cnt_a1", 32'(hz_a.lu_cnt_o), 1);
    tick();
    @(negedge clk);
    chk("lu_done_b", 32'(ob), 32'(DEF));
    chk("lu_cnt_b2", 32'(hz_b.lu_cnt_o), 2);
    tick();
    mr = 1; xrt = 0; rs = 0; rt = 0; ut = 1;
    @(negedge clk);
    chk("rt0_nostall_a", 32'(oa), 32'(DEF));
    tick();
    idle();
    br = 1;
    @(negedge clk);
    chk("flush_a", 32'(oa), 32'(FLS));
    chk("flush_b", 32'(ob), 32'(FLS));
    tick();
    idle();
    @(negedge clk);
    chk("flush_cnt_a1", 32'(hz_a.flush_cnt_o), 1);
    tick();
    lu_hz();
    br = 1;
    @(negedge clk);
    chk("flush_lu_a", 32'(oa), 32'(FLS));
    tick();
    idle();
    @(negedge clk);
    chk("flush_lu_cnt_a", 32'(hz_a.lu_cnt_o), 1);
    chk("flush_lu_fl_a", 32'(hz_a.flush_cnt_o), 2);
    tick();
    req = 1; rdy = 0; br = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_a", 32'(oa), 32'(FRZ));
      tick();
    end
    rdy = 1;
    @(negedge clk);
    chk("ready_flush_a", 32'(oa), 32'(FLS));
    chk("ready_flush_b", 32'(ob), 32'(FLS));
    tick();
    idle();
    @(negedge clk);
    chk("wait_cnt_a3", 32'(hz_a.wait_cnt_o), 3);
    chk("wait_cnt_b3", 32'(hz_b.wait_cnt_o), 3);
    chk("flush_sat_a", 32'(hz_a.flush_cnt_o), 3);
    chk("no_err_a", 32'(hz_a.err_o), 0);
    tick();
    req = 1; rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_frz_a", 32'(oa), 32'(FRZ));
      chk("to_noerr_a", 32'(hz_a.err_o), 0);
      tick();
    end
    @(negedge clk);
    chk("to_err_a", 32'(hz_a.err_o), 1);
    chk("to_noerr_b", 32'(hz_b.err_o), 0);
    tick();
    idle();
    @(negedge clk);
    chk("err_sticky_a", 32'(hz_a.err_o), 1);
    chk("err_frz_a", 32'(oa), 32'(FRZ));
    chk("ready_def_b", 32'(ob), 32'(DEF));
    tick();
    rst = 1;
    @(negedge clk);
    chk("rst_pulse_outs_a", 32'(oa), 32'(DEF));
    tick();
    rst = 0;
    @(negedge clk);
    chk("clr_err_a", 32'(hz_a.err_o), 0);
    chk("clr_lu_a", 32'(hz_a.lu_cnt_o), 0);
    chk("clr_fl_a", 32'(hz_a.flush_cnt_o), 0);
    chk("clr_wt_a", 32'(hz_a.wait_cnt_o), 0);
    chk("clr_outs_a", 32'(oa), 32'(DEF));
    tick();
    for (int i = 0; i < 5; i++) begin
      lu_hz();
      tick();
      idle();
      tick();
      tick();
    end
    @(negedge clk);
    chk("lu_sat_a", 32'(hz_a.lu_cnt_o), 3);
    chk("lu_cnt_b10", 32'(hz_b.lu_cnt_o), 10);
    tick();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      xrt = 5'($urandom_range(0, 3));
      ut  = 1'($urandom_range(0, 1));
      mr  = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 5) == 0);
      req = ($urandom_range(0, 2) == 0);
      if ((i / 200) % 2 == 0)
        rdy = ($urandom_range(0, 9) < 7);
      else
        rdy = ($urandom_range(0, 9) < 3);
      tick();
    end
    rst = 1;
    idle();
    tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
